// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one synchronous memory port (fixed 1-cycle read latency) between
//   NREQ requesters. Round-robin arbitration, with a per-requester lock that
//   keeps the grant across consecutive accesses.
//
// Build option:
//   MEM_ARB_FIXED_PRIO_EN - when defined, the winner is always the lowest
//   index requesting; the round-robin pointer is not built. Lock/HOLD
//   behaviour is the same in both builds.
//
// Handshake (req/ack):
//   A requester raises req[i] with we[i]/addr[i]/wdata[i] stable and holds
//   them until it sees ack[i]. ack[i] is a single-cycle pulse. On the edge
//   where ack is seen, the requester drops or renews req. Inputs are latched
//   at grant, so a req dropped after grant does not cancel the access.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req/lock/we     per-requester request, keep-grant, write select
//   addr/wdata      flattened per-requester address / write data
//   grant           one-hot owner (0 when idle)
//   ack             one-cycle completion pulse to the owner
//   rdata           read data, valid in the ack cycle of a read
//   busy            high whenever the FSM is not IDLE
//   mem_*           memory strobe, write enable, address, write data
//   mem_rdata       memory read data, one cycle after a read strobe
//   dbg_state       current FSM state, for observation only
module mem_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 16,
  parameter int DW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   lock,
  input  logic [NREQ-1:0]   we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   ack,
  output logic [DW-1:0]     rdata,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata,
  output logic [2:0]        dbg_state
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACK, HOLD} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   owner, owner_n;
  logic [IW-1:0]   winner;
  logic [IW-1:0]   src;
  logic            load;
  logic [NREQ-1:0] grant_n;
  logic            mem_we_n;
  logic [AW-1:0]   mem_addr_n;
  logic [DW-1:0]   mem_wdata_n;

  assign dbg_state = state;

`ifdef MEM_ARB_FIXED_PRIO_EN
  function automatic logic [IW-1:0] pick(input logic [NREQ-1:0] r);
    logic [IW-1:0] w;
    w = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (r[i]) w = IW'(i);
    end
    return w;
  endfunction

  assign winner = pick(req);
`else
  // Index of the most recently served requester; the search starts just
  // above it so every requester gets a turn.
  logic [IW-1:0] ptr;

  function automatic logic [IW-1:0] pick(input logic [NREQ-1:0] r,
                                         input logic [IW-1:0]   p);
    logic [IW-1:0] w;
    logic          found;
    int            c;
    w     = '0;
    found = 1'b0;
    for (int d = 1; d <= NREQ; d++) begin
      c = (int'(p) + d) % NREQ;
      if (!found && r[c]) begin
        w     = IW'(c);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  assign winner = pick(req, ptr);
`endif

  always_comb begin
    state_n     = state;
    owner_n     = owner;
    grant_n     = grant;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    load        = 1'b0;
    src         = owner;
    case (state)
      IDLE: begin
        if (|req) begin
          src     = winner;
          load    = 1'b1;
          owner_n = winner;
          grant_n = NREQ'(1) << winner;
          state_n = ISSUE;
        end
      end
      ISSUE: state_n = mem_we ? ACK : WAIT;
      WAIT:  state_n = ACK;
      ACK: begin
        if (lock[owner]) begin
          state_n = HOLD;
        end else begin
          grant_n = '0;
          state_n = IDLE;
        end
      end
      HOLD: begin
        if (req[owner]) begin
          load    = 1'b1;
          state_n = ISSUE;
        end else if (!lock[owner]) begin
          grant_n = '0;
          state_n = IDLE;
        end
      end
      default: begin
        grant_n = '0;
        state_n = IDLE;
      end
    endcase
    if (load) begin
      mem_we_n    = we[src];
      mem_addr_n  = addr[int'(src)*AW +: AW];
      mem_wdata_n = wdata[int'(src)*DW +: DW];
    end
  end

  // Outputs are registered from the next-state decode so each one lines up
  // with the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= '0;
      grant     <= '0;
      ack       <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      ptr       <= IW'(NREQ - 1);
`endif
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      grant     <= grant_n;
      ack       <= (state_n == ACK) ? grant_n : '0;
      busy      <= (state_n != IDLE);
      mem_en    <= (state_n == ISSUE);
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      if (state == WAIT) rdata <= mem_rdata;
`ifndef MEM_ARB_FIXED_PRIO_EN
      if (state == ACK) ptr <= owner;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: transaction-level reference model compared
// against every output on every cycle, plus directed scenarios with
// hand-computed literal expectations.
module tb_mem_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 16;
  localparam int DW   = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req, lock, we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    grant, ack;
  logic [DW-1:0]      rdata;
  logic               busy, mem_en, mem_we;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic [DW-1:0]      mem_rdata;
  logic [2:0]         dbg_state;

  mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we),
    .addr(addr), .wdata(wdata), .grant(grant), .ack(ack), .rdata(rdata),
    .busy(busy), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // ---------------- memory responder ----------------
  logic [DW-1:0] mem_arr [256];
  always @(posedge clk) begin
    if (rst) begin
      mem_rdata        <= '0;
      mem_arr[8'h10]   <= 16'h1234;
    end else if (mem_en) begin
      if (mem_we) mem_arr[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= mem_arr[mem_addr[7:0]];
    end
  end

  // ---------------- scoreboard counters ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the current owner, whether an access is in flight and how many
  // cycles have passed since its strobe; outputs follow from those facts.
  logic [NREQ-1:0] m_grant, m_ack;
  logic [DW-1:0]   m_rdata, m_wdata;
  logic [AW-1:0]   m_addr;
  logic            m_busy, m_en, m_we;
  int              m_owner, m_last, m_age, m_pick;
  bit              m_active, m_write, m_hold;
  bit              m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_grant = '0; m_ack = '0; m_rdata = '0; m_wdata = '0; m_addr = '0;
      m_busy = 1'b0; m_en = 1'b0; m_we = 1'b0;
      m_owner = -1; m_last = NREQ - 1; m_age = 0;
      m_active = 1'b0; m_write = 1'b0; m_hold = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_en   = 1'b0;
      m_ack  = '0;
      m_pick = -1;
      if (m_active) begin
        if (m_age == (m_write ? 1 : 2)) begin
          // the ack cycle is ending
          m_active = 1'b0;
          m_last   = m_owner;
          if (lock[m_owner]) m_hold = 1'b1;
          else               m_owner = -1;
        end else begin
          if (!m_write && m_age == 1) m_rdata = mem_rdata;
          m_age++;
          if (m_age == (m_write ? 1 : 2)) m_ack[m_owner] = 1'b1;
        end
      end else if (m_hold) begin
        if (req[m_owner]) begin
          m_pick = m_owner;
          m_hold = 1'b0;
        end else if (!lock[m_owner]) begin
          m_hold  = 1'b0;
          m_owner = -1;
        end
      end else if (req != '0) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        for (int i = NREQ - 1; i >= 0; i--) if (req[i]) m_pick = i;
`else
        for (int d = NREQ; d >= 1; d--) if (req[(m_last + d) % NREQ]) m_pick = (m_last + d) % NREQ;
`endif
      end
      if (m_pick >= 0) begin
        m_owner  = m_pick;
        m_active = 1'b1;
        m_age    = 0;
        m_write  = we[m_pick];
        m_we     = we[m_pick];
        m_addr   = addr[m_pick*AW +: AW];
        m_wdata  = wdata[m_pick*DW +: DW];
        m_en     = 1'b1;
      end
      m_grant = '0;
      if (m_owner >= 0) m_grant[m_owner] = 1'b1;
      m_busy = (m_owner >= 0);
    end
  end

  // single compare process, mid-cycle
  always @(negedge clk) begin
    if (m_valid) begin
      chk("grant",     grant,     m_grant);
      chk("ack",       ack,       m_ack);
      chk("rdata",     rdata,     m_rdata);
      chk("busy",      busy,      m_busy);
      chk("mem_en",    mem_en,    m_en);
      chk("mem_we",    mem_we,    m_we);
      chk("mem_addr",  mem_addr,  m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[i]              = w;
    addr[i*AW +: AW]   = a;
    wdata[i*DW +: DW]  = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // steps until an ack shows up (bounded); returns the acked index or -1
  task automatic wait_ack(output int who);
    who = -1;
    for (int k = 0; k < 12; k++) begin
      step();
      if (ack != '0) begin
        for (int i = 0; i < NREQ; i++) if (ack[i]) who = i;
        break;
      end
    end
  endtask

  // ---------------- directed scenarios ----------------
  int who;
  int n_ack;
  logic [DW-1:0] ack_rdata;
  int rr_exp [5];

  initial begin
`ifdef MEM_ARB_FIXED_PRIO_EN
    rr_exp = '{0, 0, 0, 0, 0};
`else
    rr_exp = '{0, 1, 2, 3, 0};
`endif
    rst = 1'b1; req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
    step();
    step();
    rst = 1'b0;

    // reset values
    chk("rst_grant", grant, 0);
    chk("rst_ack",   ack,   0);
    chk("rst_busy",  busy,  0);
    chk("rst_en",    mem_en, 0);
    chk("rst_rdata", rdata, 0);

    // single write from requester 0
    set_port(0, 1'b1, 16'h0040, 16'hBEEF);
    req = 4'b0001;
    step();                                   // cycle 1
    chk("wr_en_c1",   mem_en,   1);
    chk("wr_addr_c1", mem_addr, 16'h0040);
    chk("wr_we_c1",   mem_we,   1);
    chk("wr_busy_c1", busy,     1);
    chk("wr_grant_c1", grant,   4'b0001);
    step();                                   // cycle 2
    chk("wr_ack_c2",  ack,  4'b0001);
    chk("wr_busy_c2", busy, 1);
    req = '0;
    step();                                   // cycle 3
    chk("wr_ack_c3",  ack,  0);
    chk("wr_busy_c3", busy, 0);

    // single read from requester 1 (0x1234 preloaded at 0x0010)
    set_port(1, 1'b0, 16'h0010, 16'h0000);
    req = 4'b0010;
    step();
    chk("rd_en_c1",    mem_en, 1);
    chk("rd_grant_c1", grant,  4'b0010);
    step();
    chk("rd_ack_c2",   ack,    0);
    step();
    chk("rd_ack_c3",   ack,    4'b0010);
    chk("rd_data_c3",  rdata,  16'h1234);
    req = '0;
    step();

    // round robin with all four requesting
    do_reset();
    for (int i = 0; i < NREQ; i++) set_port(i, 1'b1, 16'(16'h0080 + i), 16'(16'hA000 + i));
    lock = '0;
    req  = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_ack(who);
      chk("rr_order", who, rr_exp[n]);
    end
    req = '0;
    step();
    step();

    // lock: two accesses by requester 0 before requester 2 is served
    do_reset();
    set_port(0, 1'b1, 16'h0090, 16'h1111);
    set_port(2, 1'b1, 16'h0092, 16'h2222);
    lock = 4'b0001;
    req  = 4'b0101;
    wait_ack(who);
    chk("lock_first", who, 0);
    wait_ack(who);
    chk("lock_second", who, 0);
    req = 4'b0100;
    step();
    chk("lock_hold_grant", grant, 4'b0001);
    chk("lock_hold_busy",  busy,  1);
    step();
    chk("lock_hold_grant2", grant, 4'b0001);
    chk("lock_hold_en",     mem_en, 0);
    lock = '0;
    step();
    chk("lock_release", grant, 0);
    wait_ack(who);
    chk("lock_then_req2", who, 2);
    req = '0;
    step();
    step();

    // reset in the middle of a read
    set_port(3, 1'b0, 16'h0020, 16'h0000);
    req = 4'b1000;
    step();
    chk("mid_issue_grant", grant, 4'b1000);
    step();
    chk("mid_wait_ack", ack, 0);
    rst = 1'b1;
    step();
    chk("mid_rst_grant", grant,     0);
    chk("mid_rst_ack",   ack,       0);
    chk("mid_rst_rdata", rdata,     0);
    chk("mid_rst_busy",  busy,      0);
    chk("mid_rst_en",    mem_en,    0);
    chk("mid_rst_we",    mem_we,    0);
    chk("mid_rst_addr",  mem_addr,  0);
    chk("mid_rst_wdata", mem_wdata, 0);
    rst = 1'b0;
    req = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("mid_no_ack", ack, 0);
    end
    for (int i = 0; i < NREQ; i++) set_port(i, 1'b1, 16'(16'h00A0 + i), 16'(16'hC000 + i));
    req = 4'b1111;
    step();
    chk("post_rst_grant", grant, 4'b0001);
    wait_ack(who);
    chk("post_rst_ack", who, 0);
    req = '0;
    step();
    step();

    // requester 1 drops req during ISSUE; the read still completes once
    set_port(1, 1'b0, 16'h0040, 16'h0000);
    req = 4'b0010;
    step();
    chk("drop_grant", grant, 4'b0010);
    req = '0;
    n_ack = 0;
    ack_rdata = '0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (ack != '0) begin
        n_ack++;
        ack_rdata = rdata;
        chk("drop_ack_who", ack, 4'b0010);
      end
    end
    chk("drop_ack_count", n_ack, 1);
    chk("drop_rdata", ack_rdata, 16'hBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single shared memory port between NREQ requesters: CPU controller, display refresh, and future DMA.
- Each requester sees a req/ack handshake. The block drives the synchronous memory's enable/write/address/data, assuming a fixed 1-cycle read latency.
- Round-robin by default, with an optional per-requester lock so multi-access sequences (PUSH/POP, indirect ALU ops) are not interleaved.

Parameters:
- NREQ, 4, number of requesters (2..8)
- AW, 16, address width
- DW, 16, data width

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester request; hold with addr/we/wdata stable until ack
- lock  in  NREQ  per-requester: keep grant after this access
- we  in  NREQ  per-requester: 1 = write, 0 = read
- addr  in  NREQ*AW  flattened addresses; requester i at [i*AW +: AW]
- wdata  in  NREQ*DW  flattened write data; requester i at [i*DW +: DW]
- grant  out  NREQ  one-hot current owner; 0 when idle
- ack  out  NREQ  one-cycle completion pulse to owner
- rdata  out  DW  read data; valid in the ack cycle of a read
- busy  out  1  high in every state except IDLE
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid 1 cycle after a read strobe

Behaviour:
- All outputs are registered.
- Reset values: grant=0, ack=0, rdata=0, busy=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0. State=IDLE. Priority pointer ptr=NREQ-1, so requester 0 wins first.
- FSM states: IDLE, ISSUE, WAIT, ACK, HOLD.
- IDLE:
  - If req!=0, pick winner g = first set bit searching from (ptr+1) mod NREQ upward with wrap.
  - Set grant=onehot(g) and latch addr[g], we[g], wdata[g] into mem_addr/mem_we/mem_wdata. Go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: mem_en=1 for exactly this cycle. Write -> ACK; read -> WAIT.
- WAIT: sample mem_rdata into rdata; go to ACK.
- ACK:
  - ack[g]=1 for exactly one cycle; ptr<=g.
  - req is ignored in this cycle.
  - If lock[g]=1 -> HOLD with grant kept; else -> IDLE with grant cleared.
- HOLD:
  - If req[g]=1: latch g's request and go to ISSUE.
  - Else if lock[g]=0: clear grant and go to IDLE.
  - Else stay in HOLD. Other requesters wait.
- Requester rule: drop or renew req on the edge where ack is seen, so req in the cycle after ACK reflects a new demand.
- Latency from req sampled in IDLE (cycle 0): write ack in cycle 2; read ack in cycle 3.
- mem_en is low in IDLE, WAIT, ACK and HOLD, so there is at most one access per 3 cycles (write) or 4 cycles (read).
- mem_addr/mem_we/mem_wdata stay latched outside ISSUE. Memory must ignore them when mem_en=0.
- Inputs are latched at grant. Changing or dropping req[g] after grant does not abort the access; ack still pulses.
- A req arriving in ISSUE, WAIT or ACK is considered in the next IDLE or HOLD evaluation. There is no bypass.
- A single requester with continuous req and lock=0 gets back-to-back accesses, each with one IDLE cycle between ACK and ISSUE.
- Reset mid-operation takes effect on the next edge: in-flight access is dropped, no ack is issued, mem_en is forced low, ptr is reinitialised.
- Width: winner search uses modulo-NREQ index arithmetic; ptr is clog2(NREQ) bits.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: ptr is not used. Winner is always the lowest-index set req bit, so requester 0 has highest priority. Lock/HOLD behaviour is unchanged.
- Undefined: round-robin as specified above.

Test Plan:
- Reset then single write: req=0001, we=0001, addr0=0x0040, wdata0=0xBEEF -> mem_en in cycle 1 with mem_addr=0x0040, mem_we=1; ack=0001 in cycle 2; busy 1 for cycles 1-2.
- Read: memory holds 0x1234 at 0x0010; req=0010, we=0 -> mem_en cycle 1; ack=0010 in cycle 3 with rdata=0x1234.
- Round-robin: req=1111 held, renewed after each ack -> grant order 0,1,2,3,0. With MEM_ARB_FIXED_PRIO_EN defined, order is 0,0,0,... .
- Lock: req0 with lock0=1 issues 2 accesses while req2 is continuously high -> both req0 accesses complete before grant=0100. Req2 is granted only after lock0 drops.
- Reset mid-read: assert rst during WAIT -> next cycle all outputs 0 and no ack. The first grant after reset goes to requester 0.
- Dropped req: req1 deasserted in ISSUE -> access still completes; ack=0010 pulses once.
